// File: rtl/mem_ctrl_mp_pkg.sv
// Shared encodings and helpers for the multi-port byte-serial memory controller.
package mem_ctrl_mp_pkg;

  // Request size encodings (3 is handled as a word)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Address bits [17:16] selecting the UART/IO region
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Number of bytes moved for a size code, clamped to the word width in bytes
  function automatic logic [2:0] size_nbytes(input logic [1:0] sz, input logic [2:0] max_b);
    logic [2:0] nb;
    case (sz)
      SZ_BYTE: nb = 3'd1;
      SZ_HALF: nb = 3'd2;
      SZ_WORD: nb = 3'd4;
      default: nb = 3'd4;
    endcase
    return (nb > max_b) ? max_b : nb;
  endfunction

  // Zero- or sign-extend an assembled little-endian load to 32 bits
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] nb,
                                              input logic sext);
    logic [31:0] res;
    case (nb)
      3'd1:    res = {{24{sext & raw[7]}}, raw[7:0]};
      3'd2:    res = {{16{sext & raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_ctrl_mp_rr_arbiter.sv
// Round-robin arbiter: first requester after the last accepted one wins.
module rr_arbiter
  import mem_ctrl_mp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_accept,
  output logic [NUM_PORTS-1:0] o_gnt_c,
  output logic [IDX_W-1:0]     o_idx_c,
  output logic                 o_any_c
);

  logic [IDX_W-1:0] r_last;
  logic             w_found;

  // Cyclic search starting just after the last granted port
  always_comb begin
    w_found = 1'b0;
    o_gnt_c = '0;
    o_idx_c = '0;
    for (int i = 1; i <= int'(NUM_PORTS); i++) begin
      if (!w_found && i_req[(int'(r_last) + i) % int'(NUM_PORTS)]) begin
        w_found = 1'b1;
        o_idx_c = IDX_W'((int'(r_last) + i) % int'(NUM_PORTS));
        o_gnt_c[(int'(r_last) + i) % int'(NUM_PORTS)] = 1'b1;
      end
    end
    o_any_c = w_found;
  end

  // Pointer moves only when the grant is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= IDX_W'(NUM_PORTS - 1);
    end else if (i_accept) begin
      r_last <= o_idx_c;
    end
  end

endmodule

// File: rtl/mem_ctrl_mp.sv
// Multi-port memory controller moving byte/half/word requests over an 8-bit
// memory bus. Optional build macro MEM_CTRL_MP_SIGNEXT_EN enables sign
// extension of byte and half loads.
module mem_ctrl_mp
  import mem_ctrl_mp_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        clr,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_wr,
  input  logic                        io_buffer_full,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*2-1:0]      req_size,
  input  logic [NUM_PORTS-1:0]        req_signed,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        resp_done,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        busy
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BYTES = DATA_W / 8;
  localparam logic [2:0]  MAX_B = 3'(BYTES);

  // Transaction state
  state_t              r_state;
  logic [1:0]          r_k;
  logic [IDX_W-1:0]    r_port;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_nbytes;
  logic [DATA_W-1:0]   r_wdata;
  logic [31:0]         r_cap;

  // Next-state values
  state_t              w_state_n;
  logic [1:0]          w_k_n;
  logic [31:0]         w_cap_n;
  logic [NUM_PORTS-1:0] w_done_n;
  logic [DATA_W-1:0]   w_rdata_n;
  logic                w_accept;

  // Arbiter and selected request
  logic [NUM_PORTS-1:0] w_gnt;
  logic [IDX_W-1:0]     w_gidx;
  logic                 w_any;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic                 w_sel_wr;
  logic [2:0]           w_sel_nb;
  logic [DATA_W-1:0]    w_sel_wdata;

  // Datapath helpers
  logic [2:0]          w_k1;
  logic [1:0]          w_k1_b;
  logic [ADDR_W-1:0]   w_xfer_addr;
  logic [31:0]         w_wd32;
  logic [7:0]          w_wr_byte;
  logic [31:0]         w_cap_ins;
  logic [31:0]         w_ext;
  logic                w_sext;
  logic                w_io_grant;
  logic                w_io_xfer;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_gnt_c  (w_gnt),
    .o_idx_c  (w_gidx),
    .o_any_c  (w_any)
  );

  assign w_sel_addr  = req_addr[int'(w_gidx)*int'(ADDR_W) +: ADDR_W];
  assign w_sel_wr    = req_wr[w_gidx];
  assign w_sel_nb    = size_nbytes(req_size[int'(w_gidx)*2 +: 2], MAX_B);
  assign w_sel_wdata = req_wdata[int'(w_gidx)*int'(DATA_W) +: DATA_W];

  assign w_k1        = 3'(r_k) + 3'd1;
  assign w_k1_b      = r_k + 2'd1;
  assign w_xfer_addr = r_addr + ADDR_W'(w_k1);
  assign w_wd32      = 32'(r_wdata);
  assign w_wr_byte   = w_wd32[8*int'(w_k1_b) +: 8];
  assign w_ext       = load_extend(w_cap_ins, r_nbytes, w_sext);
  assign busy        = (r_state != ST_IDLE);

  // IO region decode; narrow address spaces never reach the IO window
  generate
    if (ADDR_W >= 18) begin : g_io
      assign w_io_grant = (w_sel_addr[17:16] == IO_REGION);
      assign w_io_xfer  = (w_xfer_addr[17:16] == IO_REGION);
    end else begin : g_no_io
      assign w_io_grant = 1'b0;
      assign w_io_xfer  = 1'b0;
    end
  endgenerate

`ifdef MEM_CTRL_MP_SIGNEXT_EN
  logic r_signed;

  // Latch the sign flag of the granted request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_signed <= 1'b0;
    end else if (rdy && w_accept) begin
      r_signed <= req_signed[w_gidx];
    end
  end

  assign w_sext = r_signed;
`else
  logic w_unused_signed;
  assign w_unused_signed = ^req_signed;
  assign w_sext          = 1'b0;
`endif

  // Capture register with the current read byte merged in
  always_comb begin
    w_cap_ins = r_cap;
    w_cap_ins[8*int'(r_k) +: 8] = mem_din;
  end

  // Next-state and memory bus drive
  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_cap_n   = r_cap;
    w_done_n  = '0;
    w_rdata_n = '0;
    w_accept  = 1'b0;
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_dout  = 8'h00;
    unique case (r_state)
      ST_IDLE: begin
        // A write to the IO window waits in IDLE while the UART buffer is full
        if (!clr && w_any && !(w_sel_wr && w_io_grant && io_buffer_full)) begin
          w_accept = 1'b1;
          mem_addr = w_sel_addr;
          mem_wr   = w_sel_wr;
          mem_dout = w_sel_wr ? w_sel_wdata[7:0] : 8'h00;
          w_k_n    = 2'd0;
          w_cap_n  = '0;
          if (w_sel_wr && (w_sel_nb == 3'd1)) begin
            w_state_n = ST_GAP;
            w_done_n  = w_gnt;
          end else begin
            w_state_n = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (!r_wr) begin
          w_cap_n = w_cap_ins;
          if (clr) begin
            w_state_n = ST_IDLE;
            w_k_n     = 2'd0;
          end else if (3'(r_k) == (r_nbytes - 3'd1)) begin
            w_state_n        = ST_GAP;
            w_k_n            = 2'd0;
            w_done_n[r_port] = 1'b1;
            w_rdata_n        = DATA_W'(w_ext);
          end else begin
            mem_addr = w_xfer_addr;
            w_k_n    = r_k + 2'd1;
          end
        end else begin
          mem_addr = w_xfer_addr;
          mem_dout = w_wr_byte;
          if (!(w_io_xfer && io_buffer_full)) begin
            mem_wr = 1'b1;
            if (w_k1 == (r_nbytes - 3'd1)) begin
              w_state_n        = ST_GAP;
              w_k_n            = 2'd0;
              w_done_n[r_port] = 1'b1;
            end else begin
              w_k_n = r_k + 2'd1;
            end
          end
        end
      end
      ST_GAP: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
    if (!rdy) begin
      mem_wr   = 1'b0;
      w_accept = 1'b0;
    end
  end

  // State and response registers, frozen while rdy is low
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_k        <= 2'd0;
      r_cap      <= '0;
      resp_done  <= '0;
      resp_rdata <= '0;
    end else if (rdy) begin
      r_state    <= w_state_n;
      r_k        <= w_k_n;
      r_cap      <= w_cap_n;
      resp_done  <= w_done_n;
      resp_rdata <= w_rdata_n;
    end
  end

  // Latch the granted request's attributes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port   <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_nbytes <= 3'd1;
      r_wdata  <= '0;
    end else if (rdy && w_accept) begin
      r_port   <= w_gidx;
      r_wr     <= w_sel_wr;
      r_addr   <= w_sel_addr;
      r_nbytes <= w_sel_nb;
      r_wdata  <= w_sel_wdata;
    end
  end

endmodule

// File: doc/mem_ctrl_mp.md
MEM_CTRL_MP -- requirements
Module: mem_ctrl_mp

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requester ports, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: request and memory address width.
REQ-003 SHALL have parameter DATA_W, default 32: word width, a multiple of 8 and at most 32.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-006 SHALL have port rdy, input, 1 bit: global enable; low freezes all state.
REQ-007 SHALL have port clr, input, 1 bit: pipeline flush.
REQ-008 SHALL have port mem_din, input, 8 bits: memory read byte.
REQ-009 SHALL have port mem_dout, output, 8 bits: memory write byte.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits: memory byte address.
REQ-011 SHALL have port mem_wr, output, 1 bit: 1 = write, 0 = read.
REQ-012 SHALL have port io_buffer_full, input, 1 bit: UART buffer full.
REQ-013 SHALL have port req_valid, input, NUM_PORTS bits: per-port request; held until that port's done pulse.
REQ-014 SHALL have port req_wr, input, NUM_PORTS bits: per-port write flag.
REQ-015 SHALL have port req_addr, input, NUM_PORTS*ADDR_W bits: per-port byte address.
REQ-016 SHALL have port req_size, input, NUM_PORTS*2 bits: per-port size; 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-017 SHALL have port req_signed, input, NUM_PORTS bits: per-port load sign-extend flag.
REQ-018 SHALL have port req_wdata, input, NUM_PORTS*DATA_W bits: per-port store data.
REQ-019 SHALL have port resp_done, output, NUM_PORTS bits: one-cycle completion pulse, one bit per port.
REQ-020 SHALL have port resp_rdata, output, DATA_W bits: load data, valid only with the matching resp_done bit.
REQ-021 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, XFER, GAP; state changes only on clk rising edges with rdy=1.
REQ-023 SHALL grant in IDLE, when no clr, by round-robin: first valid port after the last granted port, in cyclic index order; the grant takes effect combinationally in the grant cycle.
REQ-024 SHALL, in the grant cycle, drive mem_addr=req_addr, mem_wr=req_wr and, for a write, mem_dout=byte0; state -> XFER with byte counter k=0.
REQ-025 SHALL, for a read in XFER: capture mem_din into byte k; drive mem_addr=addr+k+1 while k+1<nbytes; on k=nbytes-1, state -> GAP.
REQ-026 SHALL, for a write in XFER: drive byte k+1 at addr+k+1 with mem_wr=1; once all bytes are issued, state -> GAP.
REQ-027 SHALL compute addresses modulo 2^ADDR_W, with no alignment requirement.
REQ-028 SHALL, for any write byte whose address has [17:16]=2'b11 while io_buffer_full=1, drive mem_wr=0 and hold k; the same applies to a grant-cycle write, which stays in IDLE with no rr update.
REQ-029 SHALL register resp_done[p] and resp_rdata on entry to GAP: word read done in cycle grant+5; word write done in cycle grant+4; byte read done in cycle grant+2.
REQ-030 SHALL hold mem_wr=0 and issue no grant in GAP; GAP -> IDLE after one cycle.
REQ-031 SHALL zero-fill unused upper bytes of resp_rdata; resp_rdata=0 when no done pulse is asserted.
REQ-032 SHALL, on clr during a read in XFER, return to IDLE with no done pulse; clr does not affect writes in flight.
REQ-033 SHALL, in IDLE and GAP, drive mem_addr=0, mem_wr=0 and mem_dout=0.
REQ-034 SHALL, while rdy=0, hold all registers and force mem_wr=0.

Reset
REQ-035 SHALL, on rst, set state=IDLE, k=0, rr pointer = NUM_PORTS-1 (port 0 has first priority), resp_done=0, resp_rdata=0 and the capture register=0.
REQ-036 SHALL let rst mid-transfer abort the transfer with no done pulse.

Configuration
REQ-037 SHALL, with MEM_CTRL_MP_SIGNEXT_EN defined, sign-extend byte and half loads when req_signed=1.
REQ-038 SHALL, without MEM_CTRL_MP_SIGNEXT_EN, always zero-extend loads and leave req_signed unused.

Structure
REQ-039 SHALL place the size encodings, FSM state encodings and the IO region constant (2'b11 on bits [17:16]) in the shared package.
REQ-040 SHALL implement round-robin selection as sub-module rr_arbiter (NUM_PORTS request and grant vectors, pointer update on accept).

Verification
REQ-041 SHALL cover: port0 word read at 0x100, memory bytes 11 22 33 44 -> resp_done[0] at grant+5, resp_rdata=0x44332211.
REQ-042 SHALL cover: ports 0 and 1 requesting continuously -> grants alternate 0,1,0,1 with no starvation.
REQ-043 SHALL cover: byte write 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those 3 cycles, then one write, done one cycle later.
REQ-044 SHALL cover: clr two cycles into a word read -> no resp_done, IDLE next cycle; clr during a word write -> write completes with done.
REQ-045 SHALL cover: signed byte load of 0x80 -> 0xFFFFFF80 with MEM_CTRL_MP_SIGNEXT_EN, 0x00000080 without.
REQ-046 SHALL cover: rst asserted in XFER -> IDLE, busy=0, no done pulse; rdy=0 mid-read -> state frozen, completes correctly after rdy returns.
